// File: rtl/pwm16bits_gate_out.sv
// Final gate-drive stage: per-leg dead-time FSMs, mask gating and latched fault shutdown
// producing complementary high/low gate signals for NLEGS half-bridge legs.
module pwm16bits_gate_out #(
    parameter int unsigned NLEGS = 16,
    parameter int unsigned DTW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [NLEGS-1:0]   pwm_in,
    input  logic [2*NLEGS-1:0] mask_in,
    input  logic [DTW-1:0]     dt,
    input  logic               fault,
    input  logic               fault_clr,
    output logic [2*NLEGS-1:0] gate_out,
    output logic [NLEGS-1:0]   dead_active,
    output logic               fault_active
);

    typedef enum logic [1:0] {StDead, StHigh, StLow} leg_state_e;

    leg_state_e         state_q [NLEGS];
    leg_state_e         state_d [NLEGS];
    logic [DTW-1:0]     cnt_q   [NLEGS];
    logic [DTW-1:0]     cnt_d   [NLEGS];
    logic [NLEGS-1:0]   target_q, target_d;
    logic [2*NLEGS-1:0] gate_q, gate_d;
    logic               fault_active_q, fault_active_d;

    always_comb begin
        fault_active_d = fault_active_q;
        if (fault) begin
            fault_active_d = 1'b1;
        end else if (fault_clr) begin
            fault_active_d = 1'b0;
        end
    end

    always_comb begin
        target_d = target_q;
        gate_d   = '0;
        for (int i = 0; i < NLEGS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (fault_active_q) begin
                // Held in DEAD so a full dead time follows the fault clear.
                state_d[i]  = StDead;
                cnt_d[i]    = dt;
                target_d[i] = pwm_in[i];
            end else if (ce) begin
                unique case (state_q[i])
                    StHigh: begin
                        if (!pwm_in[i]) begin
                            state_d[i]  = StDead;
                            cnt_d[i]    = dt;
                            target_d[i] = 1'b0;
                        end
                    end
                    StLow: begin
                        if (pwm_in[i]) begin
                            state_d[i]  = StDead;
                            cnt_d[i]    = dt;
                            target_d[i] = 1'b1;
                        end
                    end
                    StDead: begin
                        // A pwm change inside the dead time restarts it: short pulses vanish.
                        if (pwm_in[i] != target_q[i]) begin
                            target_d[i] = pwm_in[i];
                            cnt_d[i]    = dt;
                        end else if (cnt_q[i] == '0) begin
                            state_d[i] = target_q[i] ? StHigh : StLow;
                        end else begin
                            cnt_d[i] = cnt_q[i] - DTW'(1);
                        end
                    end
                    default: begin
                        state_d[i]  = StDead;
                        cnt_d[i]    = dt;
                        target_d[i] = pwm_in[i];
                    end
                endcase
            end
            gate_d[2*i]   = (state_q[i] == StHigh) && mask_in[2*i] && !fault_active_q && !fault;
            gate_d[2*i+1] = (state_q[i] == StLow) && mask_in[2*i+1] && !fault_active_q && !fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NLEGS; i++) begin
                state_q[i] <= StDead;
                cnt_q[i]   <= dt;
            end
            target_q       <= pwm_in;
            gate_q         <= '0;
            fault_active_q <= 1'b0;
        end else begin
            for (int i = 0; i < NLEGS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            target_q       <= target_d;
            gate_q         <= gate_d;
            fault_active_q <= fault_active_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NLEGS; i++) begin
            dead_active[i] = (state_q[i] == StDead);
        end
    end

    assign gate_out     = gate_q;
    assign fault_active = fault_active_q;

endmodule

// File: tb/tb_pwm16bits_gate_out.sv
// Bench for pwm16bits_gate_out: per-cycle vector table with a scoreboard queue,
// followed by a random run checking that no leg ever drives both switches.
module tb_pwm16bits_gate_out;

    localparam logic [31:0] MF = 32'hFFFF_FFFF;
    localparam logic [31:0] HI = 32'h5555_5555;
    localparam logic [31:0] LO = 32'hAAAA_AAAA;
    localparam logic [15:0] P1 = 16'hFFFF;
    localparam logic [15:0] P0 = 16'h0000;
    localparam logic [15:0] D1 = 16'hFFFF;
    localparam logic [15:0] D0 = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, ce, fault, fault_clr;
    logic [15:0] pwm_in;
    logic [31:0] mask_in;
    logic [7:0]  dt;
    logic [31:0] gate_out;
    logic [15:0] dead_active;
    logic        fault_active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst, ce, fault, clr;
        logic [15:0] pwm;
        logic [31:0] mask;
        logic [7:0]  dt;
        logic [31:0] egate;
        logic [15:0] edead;
        logic        efa;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] gate;
        logic [15:0] dead;
        logic        fa;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    pwm16bits_gate_out #(.NLEGS(16), .DTW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .pwm_in       (pwm_in),
        .mask_in      (mask_in),
        .dt           (dt),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .gate_out     (gate_out),
        .dead_active  (dead_active),
        .fault_active (fault_active)
    );

    always #5 clk = ~clk;

    function automatic void add(input string name, input logic r, input logic c,
                                input logic [15:0] p, input logic [31:0] m, input logic [7:0] d,
                                input logic f, input logic cl, input logic [31:0] eg,
                                input logic [15:0] ed, input logic efa);
        vec_t v;
        v.name = name; v.rst = r; v.ce = c; v.pwm = p; v.mask = m; v.dt = d;
        v.fault = f; v.clr = cl; v.egate = eg; v.edead = ed; v.efa = efa;
        vecs.push_back(v);
    endfunction

    task automatic check_overlap(input string name);
        checks++;
        if ((gate_out & (gate_out >> 1) & HI) != 32'h0) begin
            errors++;
            $display("FAIL %s overlap: gate_out=%h has a leg with both switches on", name, gate_out);
        end
    endtask

    task automatic compare_outputs();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
            return;
        end
        e = exp_q.pop_front();
        if (gate_out !== e.gate) begin
            errors++;
            $display("FAIL %s gate_out: got %h expected %h", e.name, gate_out, e.gate);
        end
        checks++;
        if (dead_active !== e.dead) begin
            errors++;
            $display("FAIL %s dead_active: got %h expected %h", e.name, dead_active, e.dead);
        end
        checks++;
        if (fault_active !== e.fa) begin
            errors++;
            $display("FAIL %s fault_active: got %b expected %b", e.name, fault_active, e.fa);
        end
        check_overlap(e.name);
    endtask

    initial begin
        exp_t e;
        //   name      rst ce pwm  mask            dt fault clr gate           dead           fa
        add("rst",       1, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("pwrup1",    0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("pwrup2",    0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("pwrup3",    0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("pwrup4",    0, 1, P0, MF,            3, 0, 0, 32'h0,         D0,            0);
        add("pwrup_lo",  0, 1, P0, MF,            3, 0, 0, LO,            D0,            0);
        add("lo_hold",   0, 1, P0, MF,            3, 0, 0, LO,            D0,            0);
        add("rise0",     0, 1, P1, MF,            3, 0, 0, LO,            D1,            0);
        add("rise1",     0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("rise2",     0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("rise3",     0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("rise4",     0, 1, P1, MF,            3, 0, 0, 32'h0,         D0,            0);
        add("rise_hi",   0, 1, P1, MF,            3, 0, 0, HI,            D0,            0);
        add("hi_hold",   0, 1, P1, MF,            3, 0, 0, HI,            D0,            0);
        add("fall0",     0, 1, P0, MF,            3, 0, 0, HI,            D1,            0);
        add("fall1",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("fall2",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("fall3",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("fall4",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D0,            0);
        add("fall_lo",   0, 1, P0, MF,            3, 0, 0, LO,            D0,            0);
        add("up0",       0, 1, P1, MF,            3, 0, 0, LO,            D1,            0);
        add("up1",       0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("up2",       0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("up3",       0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("up4",       0, 1, P1, MF,            3, 0, 0, 32'h0,         D0,            0);
        add("up_hi",     0, 1, P1, MF,            3, 0, 0, HI,            D0,            0);
        add("glitch0",   0, 1, P0, MF,            3, 0, 0, HI,            D1,            0);
        add("glitch1",   0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("glitch2",   0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("glitch3",   0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("glitch4",   0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("glitch5",   0, 1, P1, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("glitch6",   0, 1, P1, MF,            3, 0, 0, 32'h0,         D0,            0);
        add("glitch_hi", 0, 1, P1, MF,            3, 0, 0, HI,            D0,            0);
        add("mask_clr",  0, 1, P1, 32'hFFFF_FFFE, 3, 0, 0, 32'h5555_5554, D0,            0);
        add("mask_hold", 0, 1, P1, 32'hFFFF_FFFE, 3, 0, 0, 32'h5555_5554, D0,            0);
        add("mask_set",  0, 1, P1, MF,            3, 0, 0, HI,            D0,            0);
        add("ce0_a",     0, 0, P0, MF,            3, 0, 0, HI,            D0,            0);
        add("ce0_mask",  0, 0, P0, 32'hFFFF_FFFE, 3, 0, 0, 32'h5555_5554, D0,            0);
        for (int k = 0; k < 8; k++)
            add("ce0_hold", 0, 0, P0, MF,         3, 0, 0, HI,            D0,            0);
        add("ce1_0",     0, 1, P0, MF,            3, 0, 0, HI,            D1,            0);
        add("ce1_1",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("ce1_2",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("ce1_3",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("ce1_4",     0, 1, P0, MF,            3, 0, 0, 32'h0,         D0,            0);
        add("ce1_lo",    0, 1, P0, MF,            3, 0, 0, LO,            D0,            0);
        add("dtchg0",    0, 1, P1, MF,            3, 0, 0, LO,            D1,            0);
        add("dtchg1",    0, 1, P1, MF,            0, 0, 0, 32'h0,         D1,            0);
        add("dtchg2",    0, 1, P1, MF,            0, 0, 0, 32'h0,         D1,            0);
        add("dtchg3",    0, 1, P1, MF,            0, 0, 0, 32'h0,         D1,            0);
        add("dtchg4",    0, 1, P1, MF,            0, 0, 0, 32'h0,         D0,            0);
        add("dtchg_hi",  0, 1, P1, MF,            0, 0, 0, HI,            D0,            0);
        add("dt0_a",     0, 1, P0, MF,            0, 0, 0, HI,            D1,            0);
        add("dt0_b",     0, 1, P0, MF,            0, 0, 0, 32'h0,         D0,            0);
        add("dt0_lo",    0, 1, P0, MF,            3, 0, 0, LO,            D0,            0);
        add("flt_set",   0, 1, P0, MF,            3, 1, 0, 32'h0,         D0,            1);
        add("flt_hold",  0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            1);
        add("flt_clr",   0, 1, P0, MF,            3, 0, 1, 32'h0,         D1,            0);
        add("flt_dt1",   0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("flt_dt2",   0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("flt_dt3",   0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("flt_dt4",   0, 1, P0, MF,            3, 0, 0, 32'h0,         D0,            0);
        add("flt_resume",0, 1, P0, MF,            3, 0, 0, LO,            D0,            0);
        add("flt_both",  0, 1, P0, MF,            3, 1, 1, 32'h0,         D0,            1);
        add("flt_stay",  0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            1);
        add("flt_clr2",  0, 1, P0, MF,            3, 0, 1, 32'h0,         D1,            0);
        add("rst_mid",   1, 0, P0, MF,            3, 1, 0, 32'h0,         D1,            0);
        add("post_rst",  0, 1, P0, MF,            3, 0, 0, 32'h0,         D1,            0);
        add("mix0",      0, 1, 16'h00FF, MF,      3, 0, 0, 32'h0,         D1,            0);
        add("mix1",      0, 1, 16'h00FF, MF,      3, 0, 0, 32'h0,         D1,            0);
        add("mix2",      0, 1, 16'h00FF, MF,      3, 0, 0, 32'h0,         16'h00FF,      0);
        add("mix3",      0, 1, 16'h00FF, MF,      3, 0, 0, 32'hAAAA_0000, 16'h00FF,      0);
        add("mix4",      0, 1, 16'h00FF, MF,      3, 0, 0, 32'hAAAA_0000, D0,            0);
        add("mix5",      0, 1, 16'h00FF, MF,      3, 0, 0, 32'hAAAA_5555, D0,            0);

        foreach (vecs[n]) begin
            rst       = vecs[n].rst;
            ce        = vecs[n].ce;
            pwm_in    = vecs[n].pwm;
            mask_in   = vecs[n].mask;
            dt        = vecs[n].dt;
            fault     = vecs[n].fault;
            fault_clr = vecs[n].clr;
            e.gate = vecs[n].egate;
            e.dead = vecs[n].edead;
            e.fa   = vecs[n].efa;
            e.name = vecs[n].name;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            compare_outputs();
        end

        // Random pwm/ce/mask/fault activity: neither switch of a leg may ever be on together.
        for (int k = 0; k < 300; k++) begin
            rst       = 1'b0;
            ce        = 1'($urandom_range(0, 3) != 0);
            pwm_in    = 16'($urandom);
            mask_in   = ($urandom_range(0, 7) == 0) ? 32'($urandom) : MF;
            dt        = 8'($urandom_range(0, 2));
            fault     = 1'($urandom_range(0, 40) == 0);
            fault_clr = 1'($urandom_range(0, 5) == 0);
            @(posedge clk);
            #1;
            check_overlap("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
